// File: rtl/gpio_input_conditioner_if.sv
// Signal bundle for one conditioned GPIO pin: raw pad input, filter/counter
// controls, conditioned level/edge outputs, pad drive, and FSM debug state.
interface gpio_input_conditioner_if #(
  parameter int DB_W = 16,
  parameter int EC_W = 16
);
  logic            pad_in_i;
  logic [DB_W-1:0] db_len_i;
  logic            invert_i;
  logic            out_en_i;
  logic            cnt_en_i;
  logic            cnt_clr_i;
  logic            level_o;
  logic            rise_o;
  logic            fall_o;
  logic [EC_W-1:0] edge_cnt_o;
  logic            pad_out_o;
  logic            pad_oeb_o;
  logic            dbg_state_o;

  // There is no valid/ready handshake on this bundle. Controls are sampled on
  // every wb_clk_i edge. All outputs are registered. rise_o and fall_o are
  // single-cycle strobes.
  modport slave (
    input  pad_in_i, db_len_i, invert_i, out_en_i, cnt_en_i, cnt_clr_i,
    output level_o, rise_o, fall_o, edge_cnt_o, pad_out_o, pad_oeb_o,
    output dbg_state_o
  );

  modport master (
    output pad_in_i, db_len_i, invert_i, out_en_i, cnt_en_i, cnt_clr_i,
    input  level_o, rise_o, fall_o, edge_cnt_o, pad_out_o, pad_oeb_o,
    input  dbg_state_o
  );
endinterface

// File: rtl/gpio_input_conditioner.sv
// Synchronizes and debounces one GPIO pad input, reports accepted edges,
// counts them, and drives an optionally inverted copy back out to a pad.
module gpio_input_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_W        = 16,
  parameter int EC_W        = 16
) (
  input logic                    wb_clk_i,
  input logic                    wb_rst_ni,
  gpio_input_conditioner_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, CHECK = 1'b1} state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  state_e                 state_q;
  logic [DB_W-1:0]        cnt_q;
  logic [DB_W-1:0]        n_q;
  logic                   level_q;
  logic                   rise_q;
  logic                   fall_q;
  logic [EC_W-1:0]        edge_cnt_q;
  logic                   pad_out_q;
  logic                   pad_oeb_q;
  logic                   s;
  logic                   commit;

  assign s      = sync_q[SYNC_STAGES-1];
  assign commit = (state_q == CHECK) && (s != level_q) && (cnt_q == n_q);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pad_in_i};
    end
  end

  // The filter commits when the counter equals the latched length. The
  // counter therefore stops at N and cannot wrap, even for N = all ones.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (s != level_q) begin
            state_q <= CHECK;
            cnt_q   <= '0;
            n_q     <= bus.db_len_i;
          end
        end
        CHECK: begin
          if (s == level_q) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == n_q) begin
            level_q <= s;
            rise_q  <= s;
            fall_q  <= ~s;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  // Clear has priority over a commit on the same edge.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      edge_cnt_q <= '0;
    end else if (bus.cnt_clr_i) begin
      edge_cnt_q <= '0;
    end else if (commit && bus.cnt_en_i && (edge_cnt_q != {EC_W{1'b1}})) begin
      edge_cnt_q <= edge_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      pad_out_q <= 1'b0;
      pad_oeb_q <= 1'b1;
    end else begin
      pad_out_q <= level_q ^ bus.invert_i;
      pad_oeb_q <= ~bus.out_en_i;
    end
  end

  assign bus.level_o     = level_q;
  assign bus.rise_o      = rise_q;
  assign bus.fall_o      = fall_q;
  assign bus.edge_cnt_o  = edge_cnt_q;
  assign bus.pad_out_o   = pad_out_q;
  assign bus.pad_oeb_o   = pad_oeb_q;
  assign bus.dbg_state_o = state_q;

endmodule

// File: doc/gpio_input_conditioner.md
Name: gpio_input_conditioner

Overview:
- Conditions one raw user GPIO input before it feeds the pad-level output logic in user_project_wrapper.
- Synchronizes the pad input into the wb_clk_i domain, then debounces it with a programmable glitch filter.
- Detects rising and falling edges, counts accepted edges, and drives a registered, optionally inverted copy back to an output pad with io_oeb control.
- One instance per conditioned pin, for example io_in[15] in and io_out[16]/io_oeb[16] out.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on pad_in_i; legal range 2..4.
- DB_W, 16, width of the debounce length and the debounce counter.
- EC_W, 16, width of the accepted-edge counter.

Ports:
- wb_clk_i  input  1  system clock; the only clock in the block.
- wb_rst_ni  input  1  reset, asynchronous assert, active-low.
- pad_in_i  input  1  raw asynchronous pad input (io_in[n]).
- db_len_i  input  DB_W  debounce length N; latched on entry to CHECK.
- invert_i  input  1  1 = pad_out_o is the inverted filtered level.
- out_en_i  input  1  1 = drive the pad (pad_oeb_o = 0).
- cnt_en_i  input  1  1 = accepted edges increment edge_cnt_o.
- cnt_clr_i  input  1  synchronous clear of edge_cnt_o.
- level_o  output  1  debounced level, registered.
- rise_o  output  1  one-cycle pulse on an accepted 0->1 transition.
- fall_o  output  1  one-cycle pulse on an accepted 1->0 transition.
- edge_cnt_o  output  EC_W  count of accepted edges; saturates.
- pad_out_o  output  1  registered level_o XOR invert_i, to io_out[m].
- pad_oeb_o  output  1  registered ~out_en_i, to io_oeb[m].

Behaviour:
- Reset values while wb_rst_ni = 0, taking effect immediately (asynchronous):
  - synchronizer flops 0; level_o 0; rise_o 0; fall_o 0; edge_cnt_o 0.
  - pad_out_o 0; pad_oeb_o 1 (pad not driven); FSM in IDLE; debounce counter 0; latched N = 0.
- Reset released: all state is re-acquired from the first wb_clk_i edge.
- Synchronizer: pad_in_i passes through SYNC_STAGES flops; s denotes the last stage.
- Debounce FSM, two states:
  - IDLE: if s != level_o, go to CHECK; set cnt = 0 and latch N = db_len_i. Otherwise stay in IDLE.
  - CHECK, s == level_o: glitch rejected; return to IDLE and set cnt = 0. There is no level change and no pulse.
  - CHECK, s != level_o and cnt == N: commit. level_o <= s; pulse rise_o or fall_o on the same edge; return to IDLE.
  - CHECK, otherwise: cnt <= cnt + 1.
- Acceptance rule: s must differ from level_o on N+2 consecutive sampled cycles.
  - Latency from a pad_in_i change to the level_o change is SYNC_STAGES + N + 2 clock edges.
  - pad_out_o follows one edge later.
- N = 0: the minimum filter; latency is SYNC_STAGES + 2.
- N = 2^DB_W - 1: cnt never wraps, because commit occurs at equality.
- db_len_i changes while in CHECK are ignored until the next entry into CHECK.
- rise_o and fall_o are never asserted in the same cycle. Each is high for exactly one cycle per commit.
- edge_cnt_o:
  - On a commit with cnt_en_i = 1, increment by 1; saturate at 2^EC_W - 1 (no wrap).
  - cnt_clr_i = 1 sets the counter to 0 on the next edge. Clear wins over a simultaneous commit, so the count becomes 0, not 1.
  - cnt_en_i = 0: commits still update level_o and pulse rise_o/fall_o, but the count holds.
- Pad output:
  - pad_out_o <= level_o ^ invert_i every cycle.
  - pad_oeb_o <= ~out_en_i every cycle.
  - Both are registered and independent of the FSM state.
- Reset asserted mid-CHECK: the pending transition is discarded.
- Pad held high through reset release: after release the block sees a mismatch and commits a rising edge after SYNC_STAGES + N + 2 edges. This rising edge is counted if cnt_en_i = 1; this is required behaviour.
- The design is fully synchronous to wb_clk_i except the reset assert path and the first synchronizer flop input.

Test Plan:
1. Reset, then pad_in_i = 0, out_en_i = 1, invert_i = 0 -> pad_oeb_o is 1 during reset and 0 one edge after release; level_o = 0, edge_cnt_o = 0, pad_out_o = 0.
2. N = 3, SYNC_STAGES = 2; pad_in_i 0->1 held -> level_o rises exactly 7 edges after the change, rise_o high for 1 cycle, edge_cnt_o = 1, pad_out_o = 1 one edge later; with invert_i = 1, pad_out_o = 0.
3. N = 3; pad_in_i high for 4 cycles then back low -> no level_o change, no pulse, edge_cnt_o unchanged. Then a 5-cycle high pulse -> accepted, rise_o followed later by fall_o, edge_cnt_o += 2.
4. EC_W = 4 instance, 20 accepted edges with cnt_en_i = 1 -> edge_cnt_o saturates at 15. Assert cnt_clr_i on the same cycle as a commit -> edge_cnt_o = 0.
5. N = 10; drop wb_rst_ni while in CHECK with cnt = 5 -> all outputs go to reset values immediately. After release with pad_in_i = 1, exactly one rising commit at SYNC_STAGES + 12 edges.
6. Change db_len_i from 10 to 0 in the middle of CHECK -> the commit still occurs at cnt = 10; the next transition uses N = 0 (latency 4 edges).
